// File: rtl/sg_pkg.sv
// Shared types for the sliding-window front end and its smoother.
// State encoding, sample width and default window depth.
package sg_pkg;

  localparam int SG_DATA_W      = 32;
  localparam int SG_WINDOW_SIZE = 7;

  typedef logic signed [SG_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    STREAM  = 2'd2
  } sg_state_t;

endpackage

// File: rtl/sg_window_buffer.sv
// Sliding window shift register with valid/ready on both sides.
// Emits one full window per accepted sample once primed.
module sg_window_buffer
  import sg_pkg::*;
#(
  parameter int WINDOW_SIZE = SG_WINDOW_SIZE,
  parameter int DATA_W      = SG_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WINDOW_SIZE*DATA_W-1:0] data_window,
  output logic [7:0]                    fill_count,
  output logic [15:0]                   window_count
);

  localparam logic [7:0] LAST = 8'(WINDOW_SIZE - 1);
  localparam logic [7:0] FULL = 8'(WINDOW_SIZE);

  sg_state_t         state_q, state_d;
  logic [7:0]        fill_q, fill_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              mv_q, mv_d;
  logic [DATA_W-1:0] win_q [WINDOW_SIZE];
  logic [DATA_W-1:0] win_d [WINDOW_SIZE];

  logic accept;
  logic handoff;

  assign s_ready = !mv_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign handoff = mv_q && m_ready;

  // Next-state: clear wins, else shift on accept and count handoffs
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    wcnt_d  = wcnt_q;
    mv_d    = mv_q;
    for (int k = 0; k < WINDOW_SIZE; k++) begin
      win_d[k] = win_q[k];
    end
    if (clear) begin
      state_d = EMPTY;
      fill_d  = 8'd0;
      wcnt_d  = 16'd0;
      mv_d    = 1'b0;
      for (int k = 0; k < WINDOW_SIZE; k++) begin
        win_d[k] = '0;
      end
    end else begin
      if (handoff) begin
        wcnt_d = wcnt_q + 16'd1;
        mv_d   = 1'b0;
      end
      if (accept) begin
        for (int k = 0; k < WINDOW_SIZE - 1; k++) begin
          win_d[k] = win_q[k+1];
        end
        win_d[WINDOW_SIZE-1] = s_data;
        unique case (state_q)
          EMPTY: begin
            fill_d  = 8'd1;
            state_d = FILLING;
          end
          FILLING: begin
            fill_d = fill_q + 8'd1;
            if (fill_q == LAST) begin
              state_d = STREAM;
              mv_d    = 1'b1;
            end
          end
          STREAM: begin
            fill_d = FULL;
            mv_d   = 1'b1;
          end
          default: begin
            state_d = EMPTY;
            fill_d  = 8'd0;
          end
        endcase
      end
    end
  end

  // State register with immediate asynchronous flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      fill_q  <= 8'd0;
      wcnt_q  <= 16'd0;
      mv_q    <= 1'b0;
      for (int k = 0; k < WINDOW_SIZE; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wcnt_q  <= wcnt_d;
      mv_q    <= mv_d;
      for (int k = 0; k < WINDOW_SIZE; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

  for (genvar g = 0; g < WINDOW_SIZE; g++) begin : g_pack
    assign data_window[g*DATA_W +: DATA_W] = win_q[g];
  end

  assign m_valid      = mv_q;
  assign fill_count   = fill_q;
  assign window_count = wcnt_q;

endmodule

// File: tb/tb_sg_window_buffer.sv
// Directed bench for sg_window_buffer with hand-computed windows.
// Covers fill, stream, backpressure, clear, async reset, sign, wrap.
module tb_sg_window_buffer;

  localparam int W  = 7;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            clear;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            m_valid;
  logic            m_ready;
  logic [W*DW-1:0] data_window;
  logic [7:0]      fill_count;
  logic [15:0]     window_count;

  int checks   = 0;
  int failures = 0;

  sg_window_buffer #(
    .WINDOW_SIZE(W),
    .DATA_W     (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .data_window (data_window),
    .fill_count  (fill_count),
    .window_count(window_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*DW-1:0] win7(input int a, input int b,
    input int c, input int d, input int e, input int f, input int g);
    logic [W*DW-1:0] r;
    r = {g, f, e, d, c, b, a};
    return r;
  endfunction

  function automatic logic [W*DW-1:0] ramp(input int b);
    return win7(b, b+1, b+2, b+3, b+4, b+5, b+6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
  endtask

  task automatic do_clear();
    s_valid = 1'b0;
    clear   = 1'b1;
    tick();
    clear   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    #3;
    chk("rst_fill", 256'(fill_count), 256'd0);
    chk("rst_mvalid", 256'(m_valid), 256'd0);
    chk("rst_sready", 256'(s_ready), 256'd1);
    chk("rst_wcnt", 256'(window_count), 256'd0);
    chk("rst_data", 256'(data_window), 256'd0);
    #10 rst_n = 1'b1;
    tick();

    // fill 1..7 then stream 8, 9
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) feed(i);
    chk("fill6_fill", 256'(fill_count), 256'd6);
    chk("fill6_mvalid", 256'(m_valid), 256'd0);
    feed(7);
    chk("fill7_mvalid", 256'(m_valid), 256'd1);
    chk("fill7_win", 256'(data_window), 256'(ramp(1)));
    chk("fill7_wcnt", 256'(window_count), 256'd0);
    feed(8);
    chk("s8_win", 256'(data_window), 256'(ramp(2)));
    chk("s8_mvalid", 256'(m_valid), 256'd1);
    chk("s8_wcnt", 256'(window_count), 256'd1);
    feed(9);
    chk("s9_win", 256'(data_window), 256'(ramp(3)));
    chk("s9_mvalid", 256'(m_valid), 256'd1);
    chk("s9_fill", 256'(fill_count), 256'd7);
    s_valid = 1'b0;
    tick();
    chk("drain_wcnt", 256'(window_count), 256'd3);
    chk("drain_mvalid", 256'(m_valid), 256'd0);

    // backpressure
    do_clear();
    chk("clr_wcnt", 256'(window_count), 256'd0);
    chk("clr_fill", 256'(fill_count), 256'd0);
    chk("clr_data", 256'(data_window), 256'd0);
    m_ready = 1'b0;
    for (int i = 1; i <= 7; i++) feed(i);
    chk("bp_mvalid", 256'(m_valid), 256'd1);
    s_valid = 1'b1;
    s_data  = 8;
    #1;
    chk("bp_sready", 256'(s_ready), 256'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_win", 256'(data_window), 256'(ramp(1)));
    chk("bp_mvalid2", 256'(m_valid), 256'd1);
    chk("bp_wcnt", 256'(window_count), 256'd0);
    chk("bp_fill", 256'(fill_count), 256'd7);
    m_ready = 1'b1;
    #1;
    chk("bp_rel_sready", 256'(s_ready), 256'd1);
    tick();
    chk("bp_rel_win", 256'(data_window), 256'(ramp(2)));
    chk("bp_rel_wcnt", 256'(window_count), 256'd1);
    s_valid = 1'b0;
    tick();
    chk("bp_end_wcnt", 256'(window_count), 256'd2);

    // clear with concurrent sample at fill 4
    do_clear();
    for (int i = 10; i <= 13; i++) feed(i);
    chk("cl_fill4", 256'(fill_count), 256'd4);
    s_valid = 1'b1;
    s_data  = 99;
    clear   = 1'b1;
    tick();
    clear   = 1'b0;
    chk("cl_fill", 256'(fill_count), 256'd0);
    chk("cl_mvalid", 256'(m_valid), 256'd0);
    chk("cl_data", 256'(data_window), 256'd0);
    for (int i = 20; i <= 25; i++) feed(i);
    chk("cl_6_mvalid", 256'(m_valid), 256'd0);
    feed(26);
    chk("cl_7_mvalid", 256'(m_valid), 256'd1);
    chk("cl_7_win", 256'(data_window), 256'(ramp(20)));

    // async reset mid-cycle while streaming
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fill", 256'(fill_count), 256'd0);
    chk("ar_mvalid", 256'(m_valid), 256'd0);
    chk("ar_sready", 256'(s_ready), 256'd1);
    chk("ar_data", 256'(data_window), 256'd0);
    chk("ar_wcnt", 256'(window_count), 256'd0);
    #2 rst_n = 1'b1;
    tick();

    // signed pass-through after refill
    m_ready = 1'b1;
    feed(32'h8000_0000);
    feed(32'h7FFF_FFFF);
    feed(-1);
    feed(0);
    feed(1);
    feed(2);
    chk("sg_6_mvalid", 256'(m_valid), 256'd0);
    feed(-5);
    chk("sg_mvalid", 256'(m_valid), 256'd1);
    chk("sg_win", 256'(data_window),
        256'(win7(32'h8000_0000, 32'h7FFF_FFFF, -1, 0, 1, 2, -5)));

    // wrap of window_count under full throughput
    for (int i = 0; i < 65535; i++) feed(i);
    chk("wrap_ffff", 256'(window_count), 256'hFFFF);
    chk("wrap_mvalid", 256'(m_valid), 256'd1);
    feed(1);
    chk("wrap_zero", 256'(window_count), 256'd0);
    chk("wrap_win", 256'(data_window),
        256'(win7(65529, 65530, 65531, 65532, 65533, 65534, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
